// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Purpose  : Full-duplex UART transceiver on a single clock. Per-bit cycle
//            counters provide bit timing. TX uses a valid/ready handshake.
//            RX delivers each frame as a one-cycle valid pulse with frame and
//            parity flags.
// Options  : UART_CORE_PARITY_EN - when defined, an even-parity bit is added
//            after the data on TX and checked on RX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TX,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int c_tx_cnt_w = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int c_rx_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w    = $clog2(DATA_BITS);

    localparam logic [c_tx_cnt_w-1:0] c_tx_bit_last  = c_tx_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_tx_cnt_w-1:0] c_tx_stop_last = c_tx_cnt_w'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [c_rx_cnt_w-1:0] c_rx_bit_last  = c_rx_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_rx_cnt_w-1:0] c_rx_half      = c_rx_cnt_w'(CLKS_PER_BIT / 2);
    localparam logic [c_bit_w-1:0]    c_data_last    = c_bit_w'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_CORE_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_CORE_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [c_tx_cnt_w-1:0]  r_tx_cnt,   w_tx_cnt_nxt;
    logic [c_bit_w-1:0]     r_tx_bit,   w_tx_bit_nxt;
    logic [DATA_BITS-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic                   r_tx;
    logic                   w_tx_line_nxt;
    logic                   r_out_rst;
    logic                   r_rdy_en;
    logic                   w_tx_hs;
`ifdef UART_CORE_PARITY_EN
    logic                   r_tx_par;
`endif

    // Ready is held off for one whole cycle after reset release.
    assign tx_ready = r_rdy_en & ~RST & (r_tx_state == TX_IDLE);
    assign w_tx_hs  = tx_valid & tx_ready;
    assign TX       = r_tx;

    // TX next-state, counters and next line level (line is registered).
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (w_tx_hs) begin
                    w_tx_shift_nxt = tx_data;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_tx_bit_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_tx_bit_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    if (r_tx_bit == c_data_last) begin
`ifdef UART_CORE_PARITY_EN
                        w_tx_state_nxt = TX_PARITY;
`else
                        w_tx_state_nxt = TX_STOP;
`endif
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                    end
                end
            end
`ifdef UART_CORE_PARITY_EN
            TX_PARITY: begin
                if (r_tx_cnt == c_tx_bit_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (r_tx_cnt == c_tx_stop_last) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase

        case (w_tx_state_nxt)
            TX_START:  w_tx_line_nxt = 1'b0;
            TX_DATA:   w_tx_line_nxt = w_tx_shift_nxt[0];
`ifdef UART_CORE_PARITY_EN
            TX_PARITY: w_tx_line_nxt = r_tx_par;
`endif
            default:   w_tx_line_nxt = 1'b1;
        endcase
    end

    // TX state register, registered line output and post-reset ready gate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_out_rst  <= 1'b0;
            r_rdy_en   <= 1'b0;
`ifdef UART_CORE_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_line_nxt;
            r_out_rst  <= 1'b1;
            r_rdy_en   <= r_out_rst;
`ifdef UART_CORE_PARITY_EN
            if (w_tx_hs) begin
                r_tx_par <= ^tx_data;
            end
`endif
        end
    end

    // ------------------------------------------------------------------ RX
    logic                   r_rx_s1, r_rx_s2;
    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic [c_rx_cnt_w-1:0]  r_rx_cnt,   w_rx_cnt_nxt;
    logic [c_bit_w-1:0]     r_rx_bit,   w_rx_bit_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic                   w_rx_done;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_ferr;
`ifdef UART_CORE_PARITY_EN
    logic                   r_rx_par_bad, w_rx_par_bad_nxt;
    logic                   r_rx_perr;
    assign rx_parity_err = r_rx_perr;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;
    assign rx_busy      = (r_rx_state != RX_IDLE);

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // RX next-state: start-bit glitch check at half bit, then one sample per bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
`ifdef UART_CORE_PARITY_EN
        w_rx_par_bad_nxt = r_rx_par_bad;
`endif
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!r_rx_s2) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_rx_half) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_rx_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_data_last) begin
`ifdef UART_CORE_PARITY_EN
                        w_rx_state_nxt = RX_PARITY;
`else
                        w_rx_state_nxt = RX_STOP;
`endif
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                    end
                end
            end
`ifdef UART_CORE_PARITY_EN
            RX_PARITY: begin
                if (r_rx_cnt == c_rx_bit_last) begin
                    w_rx_cnt_nxt     = '0;
                    w_rx_par_bad_nxt = r_rx_s2 ^ (^r_rx_shift);
                    w_rx_state_nxt   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (r_rx_cnt == c_rx_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // RX state register and frame result registers (valid is a single pulse).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
`ifdef UART_CORE_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_rx_perr    <= 1'b0;
`endif
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_valid <= w_rx_done;
`ifdef UART_CORE_PARITY_EN
            r_rx_par_bad <= w_rx_par_bad_nxt;
`endif
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
                r_rx_ferr <= ~r_rx_s2;
`ifdef UART_CORE_PARITY_EN
                r_rx_perr <= r_rx_par_bad;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core
// Purpose  : Directed self-checking bench for uart_core with CLKS_PER_BIT=4,
//            DATA_BITS=8, STOP_BITS=1. Parity cases are built only when
//            UART_CORE_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    localparam int c_cpb = 4;
`ifdef UART_CORE_PARITY_EN
    localparam int c_par = 1;
`else
    localparam int c_par = 0;
`endif
    localparam int c_nb = 10 + c_par;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TX;
    logic       rx_line;
    logic       r_rx_drv;
    logic       r_loop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    assign rx_line = r_loop ? TX : r_rx_drv;

    always #5 CLK = ~CLK;

    uart_core #(
        .CLKS_PER_BIT (c_cpb),
        .DATA_BITS    (8),
        .STOP_BITS    (1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .TX            (TX),
        .RX            (rx_line),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial frame, bit 0 first: start, data LSB first, optional parity, stop.
    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (c_par != 0) begin
            f[9]  = par;
            f[10] = stop;
        end else begin
            f[9]  = stop;
        end
        return f;
    endfunction

    // Drive one frame on RX, then idle; capture every rx_valid pulse.
    task automatic drive_frame(input logic [11:0] f, output int pulses, output logic [7:0] d,
                               output logic fe, output logic pe);
        pulses = 0;
        d      = '0;
        fe     = 1'b0;
        pe     = 1'b0;
        for (int j = 0; j < c_nb * c_cpb + 10; j++) begin
            r_rx_drv = (j < c_nb * c_cpb) ? f[j / c_cpb] : 1'b1;
            if (rx_valid) begin
                pulses++;
                d  = rx_data;
                fe = rx_frame_err;
                pe = rx_parity_err;
            end
            tick();
        end
    endtask

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] fr;
        logic [7:0]  got [2];
        logic        gfe [2];
        logic        gpe [2];
        logic [7:0]  d;
        logic        fe, pe;
        int          pulses, hs, hs_cyc, lat, bwait;
        logic        hs_now, busy_seen, found;

        // ---------------- reset with tx_valid held
        RST      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        r_rx_drv = 1'b1;
        r_loop   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", TX, 1);
            check("rst_ready", tx_ready, 0);
            check("rst_rxv", rx_valid, 0);
        end
        RST = 1'b0;
        check("rel0_ready", tx_ready, 0);
        tick();
        check("rel1_ready", tx_ready, 0);
        check("rel1_tx", TX, 1);
        check("rel1_rxdata", rx_data, 0);
        check("rel1_ferr", rx_frame_err, 0);
        check("rel1_perr", rx_parity_err, 0);
        check("rel1_busy", rx_busy, 0);
        tick();
        check("rel2_ready", tx_ready, 1);
        check("rel2_tx", TX, 1);

        // ---------------- TX frame 0xA5 (handshake in this cycle)
        fr = mk_frame(8'hA5, ^8'hA5, 1'b1);
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int j = 1; j <= c_nb * c_cpb; j++) begin
            check("tx_bit", TX, fr[(j - 1) / c_cpb]);
            check("tx_ready_busy", tx_ready, 0);
            tick();
        end
        check("tx_ready_back", tx_ready, 1);
        check("tx_idle_high", TX, 1);

        // ---------------- loopback, two back-to-back frames
        r_loop   = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        hs       = 0;
        hs_cyc   = 0;
        lat      = -1;
        pulses   = 0;
        hs_now   = 1'b0;
        got[0] = '0; got[1] = '0; gfe[0] = 1'b1; gfe[1] = 1'b1; gpe[0] = 1'b1; gpe[1] = 1'b1;
        for (int j = 0; j < 140; j++) begin
            if (rx_valid) begin
                if (pulses < 2) begin
                    got[pulses] = rx_data;
                    gfe[pulses] = rx_frame_err;
                    gpe[pulses] = rx_parity_err;
                end
                if (pulses == 0) lat = j - hs_cyc;
                pulses++;
            end
            if (tx_valid && tx_ready) begin
                hs++;
                if (hs == 1) hs_cyc = j;
                hs_now = 1'b1;
            end
            tick();
            if (hs_now) begin
                if (hs == 1) tx_data = 8'hC3;
                else         tx_valid = 1'b0;
                hs_now = 1'b0;
            end
        end
        check("lb_handshakes", hs, 2);
        check("lb_pulses", pulses, 2);
        check("lb_data0", got[0], 8'h3C);
        check("lb_data1", got[1], 8'hC3);
        check("lb_ferr0", gfe[0], 0);
        check("lb_ferr1", gfe[1], 0);
        check("lb_perr0", gpe[0], 0);
        check("lb_perr1", gpe[1], 0);
        check("lb_latency", lat, 43 + 4 * c_par);
        r_loop   = 1'b0;
        r_rx_drv = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // ---------------- one-cycle glitch on RX
        r_rx_drv = 1'b0;
        tick();
        r_rx_drv  = 1'b1;
        busy_seen = 1'b0;
        pulses    = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_busy) busy_seen = 1'b1;
            if (rx_valid) pulses++;
            tick();
        end
        check("gl_busy_seen", busy_seen, 1);
        check("gl_busy_end", rx_busy, 0);
        check("gl_no_valid", pulses, 0);
        check("gl_data_kept", rx_data, 8'hC3);
        check("gl_ferr_kept", rx_frame_err, 0);

        // ---------------- frame error, then a good frame clears it
        drive_frame(mk_frame(8'h81, ^8'h81, 1'b0), pulses, d, fe, pe);
        check("fe_pulses", pulses, 1);
        check("fe_data", d, 8'h81);
        check("fe_flag", fe, 1);
        check("fe_perr", pe, 0);
        drive_frame(mk_frame(8'h55, ^8'h55, 1'b1), pulses, d, fe, pe);
        check("ok_pulses", pulses, 1);
        check("ok_data", d, 8'h55);
        check("ok_flag", fe, 0);
        check("ok_perr", pe, 0);

`ifdef UART_CORE_PARITY_EN
        // ---------------- parity: TX bit for 0x07, RX mismatch and match
        found = 1'b0;
        for (bwait = 0; bwait < 100 && !found; bwait++) begin
            if (tx_ready) found = 1'b1;
            else tick();
        end
        check("par_ready_wait", found, 1);
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 36; i++) tick();
        check("par_tx_bit", TX, 1);
        for (int i = 0; i < 12; i++) tick();
        drive_frame(mk_frame(8'h07, 1'b0, 1'b1), pulses, d, fe, pe);
        check("par_bad_pulses", pulses, 1);
        check("par_bad_flag", pe, 1);
        check("par_bad_data", d, 8'h07);
        check("par_bad_ferr", fe, 0);
        drive_frame(mk_frame(8'h07, 1'b1, 1'b1), pulses, d, fe, pe);
        check("par_ok_flag", pe, 0);
`endif

        // ---------------- reset in the middle of a looped-back frame
        r_loop = 1'b1;
        found  = 1'b0;
        for (bwait = 0; bwait < 100 && !found; bwait++) begin
            if (tx_ready) found = 1'b1;
            else tick();
        end
        check("mr_ready_wait", found, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("mr_tx_low", TX, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mr_tx_high", TX, 1);
        check("mr_ready", tx_ready, 0);
        check("mr_busy", rx_busy, 0);
        check("mr_rxdata", rx_data, 0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (rx_valid) pulses++;
            tick();
        end
        check("mr_no_valid", pulses, 0);
        check("mr_ready_back", tx_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
